// File: rtl/max_pool_pkg.sv
// Shared types and arithmetic helpers for the pooling datapath.
package max_pool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_L,
    RD_R,
    CMP,
    DONE
  } pool_state_t;

  // Signed maximum of two bytes.
  function automatic logic signed [7:0] smax8(input logic signed [7:0] a,
                                              input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction

  // Add bias at 9 bits, clamp to the signed byte range, then rectify.
  function automatic logic signed [7:0] sat_add_relu(input logic signed [7:0] v,
                                                     input logic signed [7:0] b);
    logic signed [8:0] s;
    logic signed [7:0] sat;
    s = $signed({v[7], v}) + $signed({b[7], b});
    if (s > 9'sd127) begin
      sat = 8'sd127;
    end else if (s < -9'sd128) begin
      sat = -8'sd128;
    end else begin
      sat = s[7:0];
    end
    return (sat < 0) ? 8'sd0 : sat;
  endfunction

endpackage

// File: rtl/max_pool_max4_reg.sv
// Two-stage signed 4-input max: the left column pair is registered on
// i_load, the right column pair is folded in combinationally afterwards.
module max4_reg (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic signed [7:0] i_a,
  input  logic signed [7:0] i_b,
  output logic signed [7:0] o_max
);
  import max_pool_pkg::*;

  logic signed [7:0] r_ml;
  logic signed [7:0] w_pair;

  assign w_pair = smax8(i_a, i_b);
  assign o_max  = smax8(r_ml, w_pair);

  // Capture the max of the left column while it is on the read bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ml <= '0;
    end else if (i_load) begin
      r_ml <= w_pair;
    end
  end

endmodule

// File: rtl/max_pool.sv
// 2x2 max pooling over a stored feature map with bias add, saturation
// and ReLU; one pooled value written every three cycles.
module max_pool #(
  parameter int H              = 26,
  parameter int W              = 26,
  parameter int LOAD_ADDR_LEN  = 9,
  parameter int STORE_ADDR_LEN = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pool,
  output logic                      pool_done,
  input  logic signed [7:0]         bias,
  output logic [LOAD_ADDR_LEN:0]    rd_addr1,
  output logic [LOAD_ADDR_LEN:0]    rd_addr2,
  input  logic signed [7:0]         rd_data1,
  input  logic signed [7:0]         rd_data2,
  output logic                      wr_en,
  output logic [STORE_ADDR_LEN:0]   wr_addr,
  output logic signed [7:0]         wr_data
);
  import max_pool_pkg::*;

  localparam int PH = H / 2;
  localparam int PW = W / 2;
  localparam int LA = LOAD_ADDR_LEN + 1;
  localparam int SA = STORE_ADDR_LEN + 1;
  localparam int CW = 16;

  pool_state_t r_state;
  pool_state_t w_next;

  logic [CW-1:0]           r_pr;
  logic [CW-1:0]           r_pc;
  logic                    w_last_col;
  logic                    w_last;
  logic [LA-1:0]           w_top;
  logic [LA-1:0]           w_bot;
  logic [SA-1:0]           w_waddr;
  logic signed [7:0]       w_max;
  logic signed [7:0]       w_result;
  logic [SA-1:0]           r_wr_addr;
  logic signed [7:0]       r_wr_data;

  assign w_last_col = (r_pc == CW'(PW - 1));
  assign w_last     = w_last_col && (r_pr == CW'(PH - 1));
  assign w_top      = LA'(2 * int'(r_pr) * W + 2 * int'(r_pc));
  assign w_bot      = w_top + LA'(W);
  assign w_waddr    = SA'(int'(r_pr) * PW + int'(r_pc));
  assign w_result   = sat_add_relu(w_max, bias);

  max4_reg u_max4 (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_state == RD_R),
    .i_a    (rd_data1),
    .i_b    (rd_data2),
    .o_max  (w_max)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; pool is only looked at in IDLE and DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (pool) w_next = RD_L;
      RD_L:    w_next = RD_R;
      RD_R:    w_next = CMP;
      CMP:     w_next = w_last ? DONE : RD_L;
      DONE:    if (!pool) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded outputs; write port shows the hold registers outside CMP.
  always_comb begin
    rd_addr1  = '0;
    rd_addr2  = '0;
    wr_en     = 1'b0;
    wr_addr   = r_wr_addr;
    wr_data   = r_wr_data;
    pool_done = 1'b0;
    case (r_state)
      RD_L: begin
        rd_addr1 = w_top;
        rd_addr2 = w_bot;
      end
      RD_R: begin
        rd_addr1 = w_top + LA'(1);
        rd_addr2 = w_bot + LA'(1);
      end
      CMP: begin
        wr_en   = 1'b1;
        wr_addr = w_waddr;
        wr_data = w_result;
      end
      DONE:    pool_done = 1'b1;
      default: ;
    endcase
  end

  // Row-major window counters, wrapping to (0,0) after the last window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr <= '0;
      r_pc <= '0;
    end else if (r_state == CMP) begin
      if (w_last_col) begin
        r_pc <= '0;
        r_pr <= w_last ? '0 : r_pr + CW'(1);
      end else begin
        r_pc <= r_pc + CW'(1);
      end
    end
  end

  // Remember the last write so the port holds it between strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (r_state == CMP) begin
      r_wr_addr <= w_waddr;
      r_wr_data <= w_result;
    end
  end

endmodule

// File: tb/tb_max_pool.sv
// Bench for max_pool: three instances (4x4, 5x5, 26x26) sharing clock,
// reset and bias, each with its own synchronous-read memory.
module tb_max_pool;

  logic clk = 1'b0;
  logic rst;
  logic signed [7:0] bias;
  logic              pool    [3];
  logic              done    [3];
  logic [9:0]        ra1     [3];
  logic [9:0]        ra2     [3];
  logic signed [7:0] rd1     [3];
  logic signed [7:0] rd2     [3];
  logic              wr_en   [3];
  logic [7:0]        wr_addr [3];
  logic signed [7:0] wr_data [3];
  logic signed [7:0] mem     [3][676];

  int n_vec = 0;
  int n_err = 0;
  int wlog[$];

  always #5 clk = ~clk;

  max_pool #(.H(4), .W(4), .LOAD_ADDR_LEN(9), .STORE_ADDR_LEN(7)) u_a (
    .clk(clk), .rst(rst), .pool(pool[0]), .pool_done(done[0]), .bias(bias),
    .rd_addr1(ra1[0]), .rd_addr2(ra2[0]), .rd_data1(rd1[0]), .rd_data2(rd2[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]));

  max_pool #(.H(5), .W(5), .LOAD_ADDR_LEN(9), .STORE_ADDR_LEN(7)) u_b (
    .clk(clk), .rst(rst), .pool(pool[1]), .pool_done(done[1]), .bias(bias),
    .rd_addr1(ra1[1]), .rd_addr2(ra2[1]), .rd_data1(rd1[1]), .rd_data2(rd2[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]));

  max_pool #(.H(26), .W(26), .LOAD_ADDR_LEN(9), .STORE_ADDR_LEN(7)) u_c (
    .clk(clk), .rst(rst), .pool(pool[2]), .pool_done(done[2]), .bias(bias),
    .rd_addr1(ra1[2]), .rd_addr2(ra2[2]), .rd_data1(rd1[2]), .rd_data2(rd2[2]),
    .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]));

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rd1[k] <= (ra1[k] < 10'd676) ? mem[k][ra1[k]] : 8'sd0;
      rd2[k] <= (ra2[k] < 10'd676) ? mem[k][ra2[k]] : 8'sd0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag,
               $signed(got), got, $signed(exp), exp, $time);
    end
  endtask

  // Expected pooled value of window (pr,pc) straight from the arithmetic rules.
  function automatic int ref_win(input int k, input int w, input int pr,
                                 input int pc, input int b);
    int m, s, v;
    m = -1000;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++) begin
        v = int'(mem[k][(2 * pr + dr) * w + 2 * pc + dc]);
        if (v > m) m = v;
      end
    s = m + b;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return (s < 0) ? 0 : s;
  endfunction

  task automatic fill_random(input int k, input int n);
    for (int i = 0; i < n; i++) mem[k][i] = 8'($urandom);
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_wr_en"}, 32'(wr_en[k]), 0);
    check({tag, "_done"},  32'(done[k]), 0);
    check({tag, "_rd"},    32'(ra1[k] | ra2[k]), 0);
  endtask

  // One complete pass, checked cycle by cycle, plus the DONE handshake.
  task automatic run_pass(input int k, input int h, input int w, input int b,
                          input int hold, output int nwr, output int first,
                          output int lastc);
    int nwin, viol, j, ph, pr, pc, a1, a2;
    int exp_q[$];
    nwin = (h / 2) * (w / 2);
    for (int r = 0; r < h / 2; r++)
      for (int c = 0; c < w / 2; c++) exp_q.push_back(ref_win(k, w, r, c, b));
    wlog.delete();
    nwr = 0; first = -1; lastc = 0; viol = 0;
    @(negedge clk);
    bias = 8'(b);
    pool[k] = 1'b1;
    for (int cyc = 1; cyc <= 3 * nwin; cyc++) begin
      @(negedge clk);
      j  = (cyc - 1) / 3;
      ph = (cyc - 1) % 3;
      pr = j / (w / 2);
      pc = j % (w / 2);
      a1 = 2 * pr * w + 2 * pc + ((ph == 1) ? 1 : 0);
      a2 = a1 + w;
      if (ph < 2) begin
        check("rd_addr1", 32'(ra1[k]), a1);
        check("rd_addr2", 32'(ra2[k]), a2);
      end else begin
        check("rd_idle", 32'(ra1[k] | ra2[k]), 0);
        check("wr_addr", 32'(wr_addr[k]), j);
        check("wr_data", 32'(wr_data[k]), exp_q[j]);
      end
      check("wr_en", 32'(wr_en[k]), (ph == 2) ? 1 : 0);
      check("done_busy", 32'(done[k]), 0);
      if (wr_en[k]) begin
        nwr++;
        lastc = cyc;
        wlog.push_back(int'(wr_data[k]));
        if (first < 0) first = int'(wr_data[k]);
      end
      if (ra1[k] != 0 && ((int'(ra1[k]) / w) >= 2 * (h / 2) || (int'(ra1[k]) % w) >= 2 * (w / 2)))
        viol++;
      if (ra2[k] != 0 && ((int'(ra2[k]) / w) >= 2 * (h / 2) || (int'(ra2[k]) % w) >= 2 * (w / 2)))
        viol++;
    end
    check("rd_range", viol, 0);
    for (int c = 0; c <= hold; c++) begin
      @(negedge clk);
      check("done_hi", 32'(done[k]), 1);
      check("done_no_wr", 32'(wr_en[k]), 0);
      check("done_no_rd", 32'(ra1[k] | ra2[k]), 0);
    end
    pool[k] = 1'b0;
    @(negedge clk);
    check("done_lo", 32'(done[k]), 0);
  endtask

  initial begin
    int nwr, first, lastc;
    logic signed [7:0] rb;

    rst = 1'b1;
    bias = '0;
    for (int k = 0; k < 3; k++) begin
      pool[k] = 1'b0;
      for (int i = 0; i < 676; i++) mem[k][i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_idle(k, "reset");
        check("reset_wr_addr", 32'(wr_addr[k]), 0);
        check("reset_wr_data", 32'(wr_data[k]), 0);
      end
    end

    // Index-valued 4x4 map, zero bias.
    for (int i = 0; i < 16; i++) mem[0][i] = 8'(i);
    run_pass(0, 4, 4, 0, 0, nwr, first, lastc);
    check("idx_nwr", nwr, 4);
    check("idx_last_cyc", lastc, 12);
    check("idx_w0", wlog[0], 5);
    check("idx_w1", wlog[1], 7);
    check("idx_w2", wlog[2], 13);
    check("idx_w3", wlog[3], 15);

    // Held pool after DONE, then a fresh pass from window 0.
    run_pass(0, 4, 4, 0, 10, nwr, first, lastc);
    check("idx2_w0", first, 5);

    // Negative window with negative bias.
    fill_random(0, 16);
    mem[0][0] = -8'sd5;  mem[0][1] = -8'sd20;
    mem[0][4] = -8'sd3;  mem[0][5] = -8'sd7;
    run_pass(0, 4, 4, -10, 0, nwr, first, lastc);
    check("neg_relu", first, 0);

    // Positive saturation.
    fill_random(0, 16);
    mem[0][0] = 8'sd100; mem[0][1] = -8'sd3;
    mem[0][4] = 8'sd50;  mem[0][5] = 8'sd7;
    run_pass(0, 4, 4, 100, 0, nwr, first, lastc);
    check("sat_hi", first, 127);

    // Negative saturation then ReLU.
    fill_random(0, 16);
    mem[0][0] = -8'sd128; mem[0][1] = -8'sd128;
    mem[0][4] = -8'sd128; mem[0][5] = -8'sd128;
    run_pass(0, 4, 4, -128, 0, nwr, first, lastc);
    check("sat_lo", first, 0);

    // Random 4x4 passes.
    for (int t = 0; t < 4; t++) begin
      fill_random(0, 16);
      rb = 8'($urandom);
      run_pass(0, 4, 4, int'(rb), 0, nwr, first, lastc);
      check("rnd4_nwr", nwr, 4);
    end

    // Odd 5x5 map: last row and column never touched.
    for (int t = 0; t < 3; t++) begin
      fill_random(1, 25);
      rb = 8'($urandom);
      run_pass(1, 5, 5, int'(rb), 0, nwr, first, lastc);
      check("odd_nwr", nwr, 4);
      check("odd_last_cyc", lastc, 12);
    end

    // Reset during the 5th window's RD_R of the 26x26 instance.
    fill_random(2, 676);
    @(negedge clk);
    bias = '0;
    pool[2] = 1'b1;
    repeat (14) @(negedge clk);
    check("mid_rdr_addr", 32'(ra1[2]), 9);
    rst = 1'b1;
    pool[2] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check_idle(2, "abort");
    end

    // Full 26x26 pass after the abort, restarting at window 0.
    rb = 8'($urandom);
    run_pass(2, 26, 26, int'(rb), 0, nwr, first, lastc);
    check("full_nwr", nwr, 169);
    check("full_last_cyc", lastc, 507);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/max_pool.md
MAX_POOL -- requirements
Module: max_pool

Interface
REQ-001 Parameter H, default 26: rows of the stored conv feature map.
REQ-002 Parameter W, default 26: columns of the stored conv feature map.
REQ-003 Parameter LOAD_ADDR_LEN, default 9: MSB index of the read address; read address width is LOAD_ADDR_LEN+1.
REQ-004 Parameter STORE_ADDR_LEN, default 7: MSB index of the write address; write address width is STORE_ADDR_LEN+1.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 pool  input  1  start request from layer control; held high until pool_done is seen.
REQ-008 pool_done  output  1  completion acknowledge.
REQ-009 bias  input  signed 8  current output-channel bias; stable while pool is high.
REQ-010 rd_addr1, rd_addr2  output  LOAD_ADDR_LEN+1 each  dual read port addresses, top and bottom window rows.
REQ-011 rd_data1, rd_data2  input  signed 8 each  read data, valid exactly 1 cycle after the address.
REQ-012 wr_en  output  1  write strobe for the pooled buffer.
REQ-013 wr_addr  output  STORE_ADDR_LEN+1  pooled output address.
REQ-014 wr_data  output  signed 8  pooled, biased, rectified value.

Function
REQ-015 The FSM SHALL have states IDLE, RD_L, RD_R, CMP, DONE.
- IDLE -> RD_L when pool = 1.
- RD_L -> RD_R.
- RD_R -> CMP.
- CMP -> RD_L if windows remain, else -> DONE.
- DONE -> IDLE when pool = 0.
REQ-016 Window (pr,pc): pr in 0..H/2-1, pc in 0..W/2-1, integer division; an odd last row or column SHALL be ignored.
REQ-017 Window traversal SHALL be row-major, pc fastest.
REQ-018 RD_L SHALL drive rd_addr1 = 2pr*W+2pc and rd_addr2 = (2pr+1)*W+2pc.
REQ-019 RD_R SHALL drive the same addresses +1.
REQ-020 In RD_R the block SHALL register mL = max(rd_data1, rd_data2) as a signed compare.
REQ-021 In CMP the block SHALL form m = max(mL, rd_data1, rd_data2).
REQ-022 s = m + bias SHALL be computed at 9 bits and saturated to [-128,127].
REQ-023 wr_data = max(s,0) (ReLU).
REQ-024 wr_en SHALL be high for exactly the CMP cycle, with wr_addr = pr*(W/2)+pc.
REQ-025 Latency: exactly 3 cycles per window; the first write occurs in the 3rd cycle after the IDLE->RD_L transition.
REQ-026 H=W=26 SHALL give 169 writes in 507 cycles.
REQ-027 pool_done SHALL be high throughout DONE and only then; it falls the cycle after pool is seen low (four-phase handshake).
REQ-028 pool staying high in DONE SHALL NOT restart the block.
REQ-029 pool dropping during RD_L/RD_R/CMP SHALL be ignored; the pass completes.
REQ-030 Outside RD_L/RD_R, rd_addr1/rd_addr2 SHALL be 0.
REQ-031 Outside CMP, wr_en = 0; wr_addr and wr_data hold their last value.

Reset
REQ-032 rst = 1 at any clock edge SHALL force:
- state IDLE;
- window counters 0;
- pool_done, wr_en, wr_addr, wr_data, rd_addr1, rd_addr2 all 0.
REQ-033 Reset mid-pass SHALL abort with no further writes.
REQ-034 A new pass after reset SHALL restart at window (0,0).

Structure
REQ-035 A shared package SHALL hold the FSM state enum and the saturating signed add/ReLU function; it is used by adder_tree as well.
REQ-036 The block SHALL be one module plus one natural sub-module, max4_reg: registered two-stage signed 4-input max.

Verification
REQ-037 Reset/idle: rst high for 2 cycles, pool = 0 -> all outputs 0 and no wr_en for 20 cycles.
REQ-038 Single pass with H=W=4, memory = index value (0..15), bias = 0:
- writes to addrs 0..3 = 5, 7, 13, 15 at cycles 3, 6, 9, 12;
- pool_done rises at cycle 13.
REQ-039 Negatives and saturation, bias = -10:
- window {-5,-20,-3,-7} -> wr_data 0;
- bias = 100 with max 100 -> wr_data 127;
- bias = -128 with max -128 -> wr_data 0.
REQ-040 Handshake:
- pool held high for 10 cycles after DONE -> pool_done stays high, no new writes;
- pool low -> pool_done low next cycle;
- pool high again -> new pass from addr 0.
REQ-041 Reset mid-pass: assert rst during the 5th window's RD_R -> no further wr_en; re-issued pool -> first write to addr 0.
REQ-042 Odd size, H=W=5: exactly 4 writes; no read addresses in row 4 or column 4.
